// File: rtl/blake_io_intf_p_pkg.sv
// rtl/blake_io_intf_p_pkg.sv - shared encodings and sizing helpers for the BLAKE2 host interface
package blake_io_pkg;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_LAST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_HASH_WAIT,
    S_HASH_OUT
  } state_e;

  // Sizes depend on the top's parameters, so they are derived through these helpers.
  function automatic int beats_f(int block_bytes, int w_bytes);
    return block_bytes / w_bytes;
  endfunction

  function automatic int idx_w_f(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int cfg_bytes_f(int ll_bytes);
    return ll_bytes + 2;
  endfunction

endpackage

// File: rtl/blake_io_intf_p_if.sv
// rtl/blake_io_intf_p_if.sv - host beat bus (valid/ready, command, data)
interface blake_io_intf_p_if #(
  parameter int W_BYTES = 1
) ();
  logic                 valid;
  logic                 ready;
  logic [1:0]           cmd;
  logic [8*W_BYTES-1:0] data;

  modport master (output valid, cmd, data, input ready);
  modport slave  (input valid, cmd, data, output ready);
endinterface

// File: rtl/blake_io_intf_p_hash_serializer.sv
// rtl/blake_io_intf_p_hash_serializer.sv - captures the digest and streams nn bytes, W_BYTES per beat
module hash_serializer #(
  parameter int W_BYTES    = 1,
  parameter int HASH_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cap_i,
  input  logic [7:0]              nn_i,
  input  logic [8*HASH_BYTES-1:0] hash_i,
  output logic                    hash_v_o,
  output logic [8*W_BYTES-1:0]    hash_o,
  output logic                    hash_last_o
);
  localparam int HB_BEATS = HASH_BYTES / W_BYTES;
  localparam int BW       = $clog2(HB_BEATS + 1);

  logic [8*HASH_BYTES-1:0] hash_q;
  logic [BW-1:0]           beat_q;
  logic                    active_q;
  logic [8:0]              n_eff, n_beats, base;
  logic [8*HASH_BYTES-1:0] shifted;

  always_comb begin
    n_eff   = ((nn_i == 8'd0) || (9'(nn_i) > 9'(HASH_BYTES))) ? 9'(HASH_BYTES) : 9'(nn_i);
    n_beats = (n_eff + 9'(W_BYTES - 1)) / 9'(W_BYTES);
    base    = 9'(beat_q) * 9'(W_BYTES);
    shifted = hash_q >> {base, 3'b000};
  end

  assign hash_v_o    = active_q;
  assign hash_last_o = active_q & (9'(beat_q) == n_beats - 9'd1);

  // Bytes beyond the requested digest length read as zero.
  always_comb begin
    hash_o = '0;
    for (int b = 0; b < W_BYTES; b++) begin
      if (active_q && ((base + 9'(b)) < n_eff)) hash_o[8*b +: 8] = shifted[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_q   <= '0;
      beat_q   <= '0;
      active_q <= 1'b0;
    end else if (cap_i) begin
      hash_q   <= hash_i;
      beat_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      beat_q <= beat_q + 1'b1;
      if (hash_last_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/blake_io_intf_p.sv
// rtl/blake_io_intf_p.sv - parametrised BLAKE2 host interface: config capture, block framing, digest output
module blake_io_intf_p
  import blake_io_pkg::*;
#(
  parameter  int W_BYTES     = 1,
  parameter  int BLOCK_BYTES = 64,
  parameter  int LL_BYTES    = 8,
  parameter  int HASH_BYTES  = 32,
  localparam int BEATS       = beats_f(BLOCK_BYTES, W_BYTES),
  localparam int IDX_W       = idx_w_f(BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  blake_io_intf_p_if.slave        host,
  output logic [7:0]              kk_o,
  output logic [7:0]              nn_o,
  output logic [8*LL_BYTES-1:0]   ll_o,
  output logic                    cfg_done_o,
  input  logic                    core_ready_i,
  output logic                    data_v_o,
  output logic [8*W_BYTES-1:0]    data_o,
  output logic [IDX_W-1:0]        data_idx_o,
  output logic                    block_first_o,
  output logic                    block_last_o,
  output logic                    block_end_o,
  input  logic                    hash_v_i,
  input  logic [8*HASH_BYTES-1:0] hash_i,
  output logic                    hash_v_o,
  output logic [8*W_BYTES-1:0]    hash_o,
  output logic                    hash_last_o
);
  localparam int               CFG_BYTES = cfg_bytes_f(LL_BYTES);
  localparam int               CNT_W     = $clog2(CFG_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CFG_FULL  = CNT_W'(CFG_BYTES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cfg_cnt_q;
  logic [7:0]            kk_q, nn_q;
  logic [8*LL_BYTES-1:0] ll_q;
  logic                  data_v_q, first_q, last_q;
  logic [8*W_BYTES-1:0]  data_q;
  logic [IDX_W-1:0]      idx_q;

  cmd_e cmd;
  logic accept, msg_beat, abort, blk_end, hash_cap;

  assign cmd      = cmd_e'(host.cmd);
  assign accept   = host.valid & host.ready;
  assign msg_beat = accept & (cmd != CMD_CONF) & ((state_q == S_DATA) | (cmd == CMD_START));
  assign abort    = accept & (cmd == CMD_CONF) & (state_q == S_DATA);
  assign blk_end  = data_v_q & (idx_q == IDX_MAX);
  assign hash_cap = hash_v_i & (state_q == S_HASH_WAIT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (msg_beat) state_d = S_DATA;
      S_DATA: begin
        if (abort)                 state_d = S_IDLE;
        else if (blk_end & last_q) state_d = S_HASH_WAIT;
      end
      S_HASH_WAIT: if (hash_v_i)    state_d = S_HASH_OUT;
      S_HASH_OUT:  if (hash_last_o) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host.ready = core_ready_i & ((state_q == S_IDLE) | (state_q == S_DATA));
  end

  // Config bytes: kk, nn, then ll little-endian shifted in from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_cnt_q <= '0;
      kk_q      <= '0;
      nn_q      <= '0;
      ll_q      <= '0;
    end else if (accept) begin
      if (cmd == CMD_CONF) begin
        if (cfg_cnt_q != CFG_FULL) begin
          if (cfg_cnt_q == '0)               kk_q <= host.data[7:0];
          else if (cfg_cnt_q == CNT_W'(1))   nn_q <= host.data[7:0];
          else                               ll_q <= {host.data[7:0], ll_q[8*LL_BYTES-1:8]};
          cfg_cnt_q <= cfg_cnt_q + 1'b1;
        end
      end else begin
        cfg_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_v_q <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      data_v_q <= msg_beat;
      if (msg_beat) data_q <= host.data;
      if (abort) begin
        idx_q   <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        if (data_v_q) idx_q <= blk_end ? '0 : idx_q + 1'b1;
        if (msg_beat & (cmd == CMD_START)) first_q <= 1'b1;
        else if (blk_end)                  first_q <= 1'b0;
        if (msg_beat & (cmd == CMD_LAST))  last_q  <= 1'b1;
        else if (blk_end)                  last_q  <= 1'b0;
      end
    end
  end

  // A START beat followed directly by LAST belongs to the last block already; look ahead so beat 0 carries it.
  assign block_last_o  = last_q | (data_v_q & (idx_q != IDX_MAX) & accept & (cmd == CMD_LAST));
  assign block_first_o = first_q;
  assign block_end_o   = blk_end;
  assign data_v_o      = data_v_q;
  assign data_o        = data_q;
  assign data_idx_o    = idx_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign ll_o          = ll_q;
  assign cfg_done_o    = (cfg_cnt_q == CFG_FULL);

  hash_serializer #(
    .W_BYTES    (W_BYTES),
    .HASH_BYTES (HASH_BYTES)
  ) u_hash_ser (
    .clk         (clk),
    .reset       (reset),
    .cap_i       (hash_cap),
    .nn_i        (nn_q),
    .hash_i      (hash_i),
    .hash_v_o    (hash_v_o),
    .hash_o      (hash_o),
    .hash_last_o (hash_last_o)
  );

endmodule

// File: doc/blake_io_intf_p.md
Name: blake_io_intf_p

Overview:
- Parametrised successor of the byte-serial BLAKE2 host interface.
- Accepts configuration and message beats `W_BYTES` wide under a valid/ready handshake.
- Frames message beats into `BLOCK_BYTES` blocks for the compression core, with first/last/end flags.
- Serialises the finished digest back to the host, `nn` bytes, `W_BYTES` per beat.
- Sits between the chip I/O pins and the BLAKE2s/BLAKE2b core.

Parameters:
- `W_BYTES`, 1, bytes per beat; power of two, 1..8.
- `BLOCK_BYTES`, 64, block size in bytes: 64 for BLAKE2s, 128 for BLAKE2b. Must be a multiple of `W_BYTES`.
- `LL_BYTES`, 8, width in bytes of the message-length field: 8 for 2s, 16 for 2b.
- `HASH_BYTES`, 32, maximum digest size in bytes: 32 for 2s, 64 for 2b.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `valid_i`  in  1  host beat valid
- `ready_o`  out  1  interface can accept a beat
- `cmd_i`  in  2  0=CONF, 1=START, 2=DATA, 3=LAST
- `data_i`  in  8*W_BYTES  host beat, byte 0 in bits [7:0]
- `kk_o`  out  8  key length
- `nn_o`  out  8  digest length
- `ll_o`  out  8*LL_BYTES  message length, little-endian
- `cfg_done_o`  out  1  all 2+LL_BYTES config bytes captured
- `core_ready_i`  in  1  core can take message beats
- `data_v_o`  out  1  message beat valid
- `data_o`  out  8*W_BYTES  message beat
- `data_idx_o`  out  log2(BLOCK_BYTES/W_BYTES)  beat index within block
- `block_first_o`  out  1  beat belongs to first block
- `block_last_o`  out  1  beat belongs to last block
- `block_end_o`  out  1  final beat of a block
- `hash_v_i`  in  1  core digest valid, 1-cycle pulse
- `hash_i`  in  8*HASH_BYTES  digest, byte 0 in bits [7:0]
- `hash_v_o`  out  1  digest beat valid
- `hash_o`  out  8*W_BYTES  digest beat
- `hash_last_o`  out  1  final digest beat

Behaviour:
- **Clock and reset:** one clock `clk`; `reset` is synchronous, active-high. When `reset` is high, every register and output clears to 0 and the FSM goes to IDLE. This also applies when `reset` is asserted mid-block or mid-digest output.
- **Handshake:** a beat is accepted when `valid_i & ready_o`. `ready_o = core_ready_i & (state==IDLE | state==DATA)`, so `ready_o` is 0 in HASH_WAIT and HASH_OUT. Non-accepted cycles change nothing.
- **FSM states:** IDLE, DATA, HASH_WAIT, HASH_OUT.
  - IDLE→DATA on an accepted START.
  - DATA→HASH_WAIT after the `block_end_o` beat of a block that has `block_last_o` set.
  - HASH_WAIT→HASH_OUT on `hash_v_i`.
  - HASH_OUT→IDLE after the `hash_last_o` beat.
  - DATA or LAST accepted in IDLE is dropped.
- **Config capture:**
  - Accepted CONF beats use `data_i[7:0]` only.
  - A byte counter selects the target: 0 → `kk`; 1 → `nn`; 2..LL_BYTES+1 shift into `ll` from the MSB end (little-endian assembly).
  - The counter saturates at LL_BYTES+2; `cfg_done_o` is 1 at saturation, and extra CONF beats are ignored.
  - Any accepted non-CONF beat clears the counter (`cfg_done_o` falls), while `kk`/`nn`/`ll` keep their values. Idle cycles do not clear the counter.
- **CONF in DATA:** aborts the block. It clears the beat index and both flags, returns the FSM to IDLE and starts config capture.
- **Message path:**
  - Latency 1: each accepted START/DATA/LAST beat appears on `data_v_o`/`data_o` the next cycle.
  - `data_idx_o` is the beat index of the presented beat. It increments after each presented beat and wraps from BLOCK_BYTES/W_BYTES−1 to 0.
  - `block_end_o = data_v_o & (data_idx_o == max)`.
  - `block_first_o` is set by START and cleared after the first `block_end_o`.
  - `block_last_o` is set by LAST and cleared after its `block_end_o`.
  - START and LAST on the same block (single-block message) is legal: the host sends the first beat as START and the rest as LAST, and both flags are high for that block.
  - The host always sends whole blocks, zero-padded; `ll_o` carries the true length.
- **Digest output:**
  - On `hash_v_i` in HASH_WAIT, `hash_i` is captured.
  - Effective length `n = nn`, clamped to 1..HASH_BYTES (`nn=0` → HASH_BYTES).
  - Beats = ceil(n/W_BYTES), one per cycle starting the cycle after capture, lowest bytes first.
  - Bytes at positions ≥ n within the last beat are driven 0.
  - `hash_last_o` accompanies the final beat.
  - `hash_v_i` outside HASH_WAIT is ignored.

Decomposition:
- **Package `blake_io_pkg`:** CMD_CONF/START/DATA/LAST encodings, FSM state enum, localparams `BEATS = BLOCK_BYTES/W_BYTES`, `IDX_W`, `CFG_BYTES = LL_BYTES+2`.
- **Sub-module `hash_serializer`:** capture register, beat counter, byte masking, `hash_last_o`. The top holds config capture, block framing and the FSM.

Test Plan:
- **Config capture:** W_BYTES=1; CONF beats 0x00,0x20,0x03,0,0,0,0,0,0,0 → `kk_o`=0, `nn_o`=0x20, `ll_o`=3, `cfg_done_o`=1 after the 10th beat; an 11th CONF leaves all unchanged.
- **Single-block message:** W_BYTES=4, BLOCK_BYTES=64; START then 15 LAST beats → `data_idx_o` 0..15, `block_first_o`=`block_last_o`=1 on all 16, `block_end_o` only on idx 15, FSM→HASH_WAIT, `ready_o`=0.
- **Backpressure:** drop `core_ready_i` for 5 cycles mid-block with `valid_i` held → `ready_o`=0, no `data_v_o`, index frozen; resumes at the same idx with no lost or duplicated beat.
- **Digest output:** `nn`=20, W_BYTES=8, `hash_v_i` with `hash_i` bytes 0x00..0x1F → 3 beats: 00..07, 08..0F, then 10..13 with upper 4 bytes 0 and `hash_last_o`=1; FSM then returns to IDLE.
- **Multi-block and abort:** 2-block message START block then LAST block → `block_first_o` only on block 1, `block_last_o` only on block 2. Separately, a CONF mid-block → index 0, flags 0, IDLE.
- **Reset mid-operation:** reset asserted during HASH_OUT beat 2 → next cycle all outputs 0, `ready_o` follows `core_ready_i`, and no further `hash_v_o`.
